// File: rtl/pe_array.sv
// Output-stationary systolic MAC array. Activations shift right along rows,
// weights shift down along columns; each PE keeps its own 32-bit accumulator
// and raises a result-valid flag when its overlapping operand stream ends.
module pe_array #(
  parameter int rows = 8,
  parameter int cols = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   fire,
  input  logic [7:0]             in_a [rows],
  input  logic [7:0]             in_w [cols],
  output logic [31:0]            outs [rows*cols],
  output logic [rows*cols-1:0]   outvalids
);

  // Forwarded operand registers of every PE, read by the right/lower neighbour.
  logic [7:0] a_fwd_s  [rows][cols];
  logic       va_fwd_s [rows][cols];
  logic [7:0] w_fwd_s  [rows][cols];
  logic       vw_fwd_s [rows][cols];

  for (genvar r = 0; r < rows; r++) begin : g_row
    for (genvar c = 0; c < cols; c++) begin : g_col
      logic [7:0]  a_in_s;
      logic [7:0]  w_in_s;
      logic        va_in_s;
      logic        vw_in_s;
      logic        en_s;
      logic [15:0] prod_s;
      logic [7:0]  a_q, a_d, w_q, w_d;
      logic        va_q, va_d, vw_q, vw_d;
      logic        en_dly_q, en_dly_d;
      logic        ov_q, ov_d;
      logic [31:0] acc_q, acc_d;

      // Left-edge PEs take the array input, others the left neighbour's register.
      if (c == 0) begin : g_a_edge
        assign a_in_s  = in_a[r];
        assign va_in_s = fire;
      end else begin : g_a_chain
        assign a_in_s  = a_fwd_s[r][c-1];
        assign va_in_s = va_fwd_s[r][c-1];
      end

      // Top-edge PEs take the array input, others the upper neighbour's register.
      if (r == 0) begin : g_w_edge
        assign w_in_s  = in_w[c];
        assign vw_in_s = fire;
      end else begin : g_w_chain
        assign w_in_s  = w_fwd_s[r-1][c];
        assign vw_in_s = vw_fwd_s[r-1][c];
      end

      assign a_fwd_s[r][c]  = a_q;
      assign va_fwd_s[r][c] = va_q;
      assign w_fwd_s[r][c]  = w_q;
      assign vw_fwd_s[r][c] = vw_q;

      // Next-state: operand shift, MAC with stream restart, result-valid tracking.
      always_comb begin
        a_d      = a_in_s;
        va_d     = va_in_s;
        w_d      = w_in_s;
        vw_d     = vw_in_s;
        en_s     = va_in_s & vw_in_s;
        en_dly_d = en_s;
        prod_s   = {8'd0, a_in_s} * {8'd0, w_in_s};
        acc_d    = acc_q;
        ov_d     = ov_q;
        if (en_s) begin
          if (!en_dly_q) begin
            // First term of a new stream discards the previous result.
            acc_d = {16'd0, prod_s};
            ov_d  = 1'b0;
          end else begin
            acc_d = acc_q + {16'd0, prod_s};
            ov_d  = ov_q;
          end
        end else begin
          if (en_dly_q) begin
            ov_d = 1'b1;
          end else begin
            ov_d = ov_q;
          end
        end
      end

      // PE state registers with asynchronous clear.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_q      <= 8'd0;
          va_q     <= 1'b0;
          w_q      <= 8'd0;
          vw_q     <= 1'b0;
          en_dly_q <= 1'b0;
          ov_q     <= 1'b0;
          acc_q    <= 32'd0;
        end else begin
          a_q      <= a_d;
          va_q     <= va_d;
          w_q      <= w_d;
          vw_q     <= vw_d;
          en_dly_q <= en_dly_d;
          ov_q     <= ov_d;
          acc_q    <= acc_d;
        end
      end

      assign outs[r*cols+c]      = acc_q;
      assign outvalids[r*cols+c] = ov_q;
    end
  end

endmodule

// File: tb/tb_pe_array.sv
// Self-checking bench for pe_array: directed tables, skewed matmul,
// random streams against a delay-history reference model, wrap and reset cases.
module tb_pe_array;
  localparam int R = 8;
  localparam int C = 8;
  localparam int N = R * C;

  logic         clk;
  logic         rstn;
  logic         fire;
  logic [7:0]   in_a [R];
  logic [7:0]   in_w [C];
  logic [31:0]  outs [N];
  logic [N-1:0] outvalids;

  pe_array #(.rows(R), .cols(C)) dut (
    .clk(clk), .rstn(rstn), .fire(fire), .in_a(in_a), .in_w(in_w),
    .outs(outs), .outvalids(outvalids)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: history of applied edge inputs; PE(r,c) sees the
  // activation applied c edges ago and the weight applied r edges ago.
  logic [7:0]  ha [16][R];
  logic [7:0]  hw [16][C];
  logic        hf [16];
  int          t = 16;
  logic [31:0] m_acc [N];
  logic        m_ov [N];
  logic        m_en [N];

  typedef struct {
    int          r;
    int          c;
    logic [31:0] exp_out;
    logic        exp_v;
  } vec_t;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) hf[i] = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_acc[i] = 32'd0; m_ov[i] = 1'b0; m_en[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int idx;
    t = t + 1;
    idx = t % 16;
    for (int r = 0; r < R; r++) ha[idx][r] = in_a[r];
    for (int c = 0; c < C; c++) hw[idx][c] = in_w[c];
    hf[idx] = fire;
    if (!rstn) begin
      model_clear();
    end else begin
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          int ia, iw, i;
          logic en;
          logic [31:0] p;
          ia = (t - c) % 16;
          iw = (t - r) % 16;
          i  = r * C + c;
          en = hf[ia] & hf[iw];
          p  = 32'(ha[ia][r]) * 32'(hw[iw][c]);
          if (en) begin
            if (!m_en[i]) begin m_acc[i] = p; m_ov[i] = 1'b0; end
            else m_acc[i] = m_acc[i] + p;
          end else if (m_en[i]) begin
            m_ov[i] = 1'b1;
          end
          m_en[i] = en;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_one(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_array(input string name);
    int bo, bv;
    bo = -1; bv = -1;
    for (int i = 0; i < N; i++) begin
      if (bo < 0 && outs[i] !== m_acc[i]) bo = i;
      if (bv < 0 && outvalids[i] !== m_ov[i]) bv = i;
    end
    n_checks++;
    if (bo >= 0) begin
      n_fail++;
      $display("FAIL %s outs[%0d]: got %0d expected %0d", name, bo, outs[bo], m_acc[bo]);
    end
    n_checks++;
    if (bv >= 0) begin
      n_fail++;
      $display("FAIL %s outvalids[%0d]: got %0d expected %0d", name, bv, outvalids[bv], m_ov[bv]);
    end
  endtask

  task automatic set_all(input logic [7:0] a, input logic [7:0] w);
    for (int r = 0; r < R; r++) in_a[r] = a;
    for (int c = 0; c < C; c++) in_w[c] = w;
  endtask

  task automatic set_rand();
    for (int r = 0; r < R; r++) in_a[r] = 8'($urandom_range(0, 255));
    for (int c = 0; c < C; c++) in_w[c] = 8'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    fire = 1'b0;
    rstn = 1'b0;
    #1;
    model_clear();
    step();
    step();
    rstn = 1'b1;
  endtask

  logic [7:0]  ma [R][8];
  logic [7:0]  mw [8][C];
  logic [31:0] sum1, sum2, expv;
  longint      wrap_l;
  vec_t        tbl [10];

  initial begin
    rstn = 1'b0;
    fire = 1'b1;
    set_rand();
    model_clear();

    // 1. reset with live inputs, then release
    for (int k = 0; k < 4; k++) begin
      step();
      check_array("reset_hold");
      set_rand();
    end
    check_one("reset_out0", outs[0], 32'd0);
    check_one("reset_valid", {31'd0, |outvalids}, 32'd0);
    rstn = 1'b1;
    fire = 1'b0;
    step();
    check_array("reset_release");

    // 2. PE(0,0) sums 1..10 with unit weights
    for (int k = 1; k <= 10; k++) begin
      set_all(8'(k), 8'd1);
      fire = 1'b1;
      step();
      check_array("seq10");
    end
    check_one("seq10_valid_before_end", {31'd0, outvalids[0]}, 32'd0);
    fire = 1'b0;
    step();
    check_one("seq10_out", outs[0], 32'd55);
    check_one("seq10_valid", {31'd0, outvalids[0]}, 32'd1);
    check_one("seq10_out01", outs[1], 32'd45);
    for (int k = 0; k < 3; k++) step();
    check_one("seq10_hold_out", outs[0], 32'd55);
    check_one("seq10_hold_valid", {31'd0, outvalids[0]}, 32'd1);

    // 3. constant 2*3 for four unskewed cycles
    do_reset();
    tbl[0] = '{0, 0, 32'd24, 1'b1};
    tbl[1] = '{1, 0, 32'd18, 1'b1};
    tbl[2] = '{0, 3, 32'd6,  1'b1};
    tbl[3] = '{3, 0, 32'd6,  1'b1};
    tbl[4] = '{0, 4, 32'd0,  1'b0};
    tbl[5] = '{7, 7, 32'd24, 1'b1};
    tbl[6] = '{2, 5, 32'd6,  1'b1};
    tbl[7] = '{5, 1, 32'd0,  1'b0};
    tbl[8] = '{7, 4, 32'd6,  1'b1};
    tbl[9] = '{6, 4, 32'd12, 1'b1};
    set_all(8'd2, 8'd3);
    for (int k = 0; k < 4; k++) begin
      fire = 1'b1;
      step();
      check_array("const4");
    end
    fire = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      check_array("const4_drain");
    end
    for (int i = 0; i < 10; i++) begin
      check_one($sformatf("const4_out_r%0d_c%0d", tbl[i].r, tbl[i].c),
                outs[tbl[i].r*C+tbl[i].c], tbl[i].exp_out);
      check_one($sformatf("const4_valid_r%0d_c%0d", tbl[i].r, tbl[i].c),
                {31'd0, outvalids[tbl[i].r*C+tbl[i].c]}, {31'd0, tbl[i].exp_v});
    end

    // 4. skewed 8x8 matmul
    do_reset();
    for (int r = 0; r < R; r++) for (int k = 0; k < 8; k++) ma[r][k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 8; k++) for (int c = 0; c < C; c++) mw[k][c] = 8'($urandom_range(0, 255));
    for (int s = 0; s < 15; s++) begin
      for (int r = 0; r < R; r++) in_a[r] = (s - r >= 0 && s - r < 8) ? ma[r][s-r] : 8'd0;
      for (int c = 0; c < C; c++) in_w[c] = (s - c >= 0 && s - c < 8) ? mw[s-c][c] : 8'd0;
      fire = 1'b1;
      step();
      check_array("matmul");
    end
    fire = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check_array("matmul_drain");
    end
    begin
      int bad;
      bad = -1;
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) begin
          expv = 32'd0;
          for (int k = 0; k < 8; k++) expv = expv + 32'(ma[r][k]) * 32'(mw[k][c]);
          if (bad < 0 && outs[r*C+c] !== expv) begin
            bad = r * C + c;
            sum1 = expv;
          end
        end
      end
      n_checks++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL matmul_result outs[%0d]: got %0d expected %0d", bad, outs[bad], sum1);
      end
    end
    check_one("matmul_all_valid", {31'd0, &outvalids}, 32'd1);

    // random streams with random fire gaps
    do_reset();
    for (int k = 0; k < 250; k++) begin
      set_rand();
      fire = ($urandom_range(0, 3) != 0);
      step();
      check_array("random");
    end

    // 6. two bursts separated by two idle cycles, then reset mid-burst
    do_reset();
    sum1 = 32'd0;
    for (int k = 0; k < 5; k++) begin
      set_rand();
      fire = 1'b1;
      sum1 = sum1 + 32'(in_a[0]) * 32'(in_w[0]);
      step();
      check_array("burst1");
    end
    fire = 1'b0;
    step();
    check_array("gap1");
    check_one("burst1_out", outs[0], sum1);
    check_one("burst1_valid", {31'd0, outvalids[0]}, 32'd1);
    step();
    check_one("gap2_valid_hold", {31'd0, outvalids[0]}, 32'd1);
    sum2 = 32'd0;
    for (int k = 0; k < 4; k++) begin
      set_rand();
      fire = 1'b1;
      sum2 = sum2 + 32'(in_a[0]) * 32'(in_w[0]);
      step();
      check_array("burst2");
      if (k == 0) check_one("burst2_start_valid", {31'd0, outvalids[0]}, 32'd0);
    end
    fire = 1'b0;
    step();
    check_one("burst2_out", outs[0], sum2);
    check_one("burst2_valid", {31'd0, outvalids[0]}, 32'd1);
    for (int k = 0; k < 10; k++) step();
    for (int k = 0; k < 3; k++) begin
      set_rand();
      fire = 1'b1;
      step();
    end
    rstn = 1'b0;
    #1;
    model_clear();
    check_array("midrst_immediate");
    check_one("midrst_out0", outs[0], 32'd0);
    for (int k = 0; k < 2; k++) begin
      set_rand();
      step();
      check_array("midrst_hold");
    end
    rstn = 1'b1;
    fire = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_array("midrst_after");
    end
    check_one("midrst_no_valid", {31'd0, |outvalids}, 32'd0);

    // 5. accumulator wrap at PE(0,0)
    do_reset();
    set_all(8'd255, 8'd255);
    fire = 1'b1;
    for (int k = 0; k < 70000; k++) step();
    wrap_l = (64'd70000 * 64'd65025) % 64'd4294967296;
    check_one("wrap_out", outs[0], 32'(wrap_l));
    fire = 1'b0;
    step();
    check_one("wrap_valid", {31'd0, outvalids[0]}, 32'd1);
    check_one("wrap_out_hold", outs[0], 32'(wrap_l));
    check_array("wrap_array");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
